// File: rtl/overlay_driver.sv
`default_nettype none
// ============================================================================
// Module      : overlay_driver
// Description : Host-side job sequencer for the PE-array overlay: instruction
//               issue, serial feed, compute wait, load strobe, result drain.
// Revision    : 1.0 - initial release
// ============================================================================
module overlay_driver #(
    parameter int DATA_WIDTH  = 16,
    parameter int INST_WIDTH  = 64,
    parameter int PE_NUM      = 8,
    parameter int INST_NUM    = 16,
    parameter int WAIT_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    prog_clr,
    input  logic                    prog_v,
    input  logic [INST_WIDTH-1:0]   prog_inst,
    input  logic                    src_v,
    input  logic [2*DATA_WIDTH-1:0] src_data,
    output logic                    src_rdy,
    output logic                    inst_in_v,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    din_overlay_v,
    output logic [2*DATA_WIDTH-1:0] din_overlay,
    output logic                    load,
    input  logic                    dout_overlay_v,
    input  logic [2*DATA_WIDTH-1:0] dout_overlay,
    output logic                    res_v,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    res_last,
    output logic                    busy,
    output logic                    done,
    output logic                    stray
);

    localparam int c_aw = (INST_NUM > 1) ? $clog2(INST_NUM) : 1;
    localparam int c_pw = c_aw + 1;
    localparam int c_cw = $clog2(PE_NUM) + 1;
    localparam int c_ww = $clog2(WAIT_CYCLES) + 1;

    localparam logic [c_pw-1:0] c_plen_max  = c_pw'(INST_NUM);
    localparam logic [c_cw-1:0] c_pe_last   = c_cw'(PE_NUM - 1);
    localparam logic [c_ww-1:0] c_wait_last = c_ww'(WAIT_CYCLES - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_inst  = 3'd1;
    localparam logic [2:0] c_st_feed  = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_load  = 3'd4;
    localparam logic [2:0] c_st_drain = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;

    logic [2:0]            r_state;
    logic [c_pw-1:0]       r_plen;
    logic [c_pw-1:0]       r_idx;
    logic [c_cw-1:0]       r_cnt;
    logic [c_ww-1:0]       r_wcnt;
    logic [INST_WIDTH-1:0] r_mem [INST_NUM];

    logic            w_idle;
    logic            w_src_hs;
    logic            w_res_hs;
    logic            w_prog_wr;
    logic [c_pw-1:0] w_idx_nxt;

    assign w_idle    = (r_state == c_st_idle);
    assign w_src_hs  = src_v && (r_state == c_st_feed);
    assign w_res_hs  = dout_overlay_v && (r_state == c_st_drain);
    assign w_prog_wr = w_idle && prog_v && !prog_clr && (r_plen != c_plen_max);
    assign w_idx_nxt = r_idx + c_pw'(1);

    assign src_rdy = (r_state == c_st_feed);
    assign load    = (r_state == c_st_load);
    assign busy    = !w_idle;
    assign done    = (r_state == c_st_done);

    // The buffer holds program contents only; it needs no reset because plen gates every read.
    always_ff @(posedge clk) begin
        if (w_prog_wr) begin
            r_mem[r_plen[c_aw-1:0]] <= prog_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_plen        <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_wcnt        <= '0;
            inst_in_v     <= 1'b0;
            inst_in       <= '0;
            din_overlay_v <= 1'b0;
            din_overlay   <= '0;
            res_v         <= 1'b0;
            res_data      <= '0;
            res_last      <= 1'b0;
            stray         <= 1'b0;
        end else begin
            inst_in_v     <= 1'b0;
            din_overlay_v <= w_src_hs;
            din_overlay   <= src_data;
            res_v         <= w_res_hs;
            res_data      <= dout_overlay;
            res_last      <= w_res_hs && (r_cnt == c_pe_last);

            case (r_state)
                c_st_idle: begin
                    if (prog_clr) begin
                        r_plen <= '0;
                    end else if (w_prog_wr) begin
                        r_plen <= r_plen + c_pw'(1);
                    end
                    if (start) begin
                        stray   <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= (r_plen == '0) ? c_st_feed : c_st_inst;
                    end
                end
                c_st_inst: begin
                    inst_in_v <= 1'b1;
                    inst_in   <= r_mem[r_idx[c_aw-1:0]];
                    r_idx     <= w_idx_nxt;
                    if (w_idx_nxt == r_plen) begin
                        r_state <= c_st_feed;
                    end
                end
                c_st_feed: begin
                    if (w_src_hs) begin
                        if (r_cnt == c_pe_last) begin
                            r_cnt   <= '0;
                            r_wcnt  <= '0;
                            r_state <= c_st_wait;
                        end else begin
                            r_cnt <= r_cnt + c_cw'(1);
                        end
                    end
                end
                c_st_wait: begin
                    if (r_wcnt == c_wait_last) begin
                        r_state <= c_st_load;
                    end else begin
                        r_wcnt <= r_wcnt + c_ww'(1);
                    end
                end
                c_st_load: begin
                    r_cnt   <= '0;
                    r_state <= c_st_drain;
                end
                c_st_drain: begin
                    if (w_res_hs) begin
                        if (r_cnt == c_pe_last) begin
                            r_state <= c_st_done;
                        end else begin
                            r_cnt <= r_cnt + c_cw'(1);
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // Placed after the FSM so a stray word on the same cycle as start still sets the flag.
            if (dout_overlay_v && (r_state != c_st_drain)) begin
                stray <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_overlay_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_overlay_driver
// Description : Self-checking bench for overlay_driver with a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_overlay_driver;

    localparam int DW = 16;
    localparam int IW = 64;
    localparam int PE = 8;
    localparam int IN = 16;
    localparam int WC = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            prog_clr = 1'b0;
    logic            prog_v = 1'b0;
    logic [IW-1:0]   prog_inst = '0;
    logic            src_v = 1'b0;
    logic [2*DW-1:0] src_data = '0;
    logic            dout_overlay_v = 1'b0;
    logic [2*DW-1:0] dout_overlay = '0;
    logic            src_rdy, inst_in_v, din_overlay_v, load;
    logic            res_v, res_last, busy, done, stray;
    logic [IW-1:0]   inst_in;
    logic [2*DW-1:0] din_overlay, res_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0, load_cnt = 0, done_cyc = 0, busy_fall_cyc = 0, last_din_cyc = 0;
    int model_plen = 0;
    logic prev_busy = 1'b0;

    logic [IW-1:0]   exp_inst[$], obs_inst[$];
    int              obs_inst_cyc[$];
    logic [2*DW-1:0] exp_din[$], obs_din[$];
    int              exp_din_cyc[$], obs_din_cyc[$];
    logic [2*DW:0]   exp_res[$], obs_res[$];
    int              exp_res_cyc[$], obs_res_cyc[$];

    overlay_driver #(
        .DATA_WIDTH(DW), .INST_WIDTH(IW), .PE_NUM(PE), .INST_NUM(IN), .WAIT_CYCLES(WC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prog_clr(prog_clr), .prog_v(prog_v),
        .prog_inst(prog_inst), .src_v(src_v), .src_data(src_data), .src_rdy(src_rdy),
        .inst_in_v(inst_in_v), .inst_in(inst_in), .din_overlay_v(din_overlay_v),
        .din_overlay(din_overlay), .load(load), .dout_overlay_v(dout_overlay_v),
        .dout_overlay(dout_overlay), .res_v(res_v), .res_data(res_data),
        .res_last(res_last), .busy(busy), .done(done), .stray(stray)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic monitor;
        forever begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (inst_in_v) begin
                obs_inst.push_back(inst_in);
                obs_inst_cyc.push_back(cyc);
            end
            if (din_overlay_v) begin
                obs_din.push_back(din_overlay);
                obs_din_cyc.push_back(cyc);
            end
            if (res_v) begin
                obs_res.push_back({res_last, res_data});
                obs_res_cyc.push_back(cyc);
            end
            if (load) load_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_busy = busy;
        end
    endtask

    task automatic prog_clear;
        @(posedge clk); #1;
        prog_clr = 1'b1;
        @(posedge clk); #1;
        prog_clr = 1'b0;
        exp_inst.delete();
        model_plen = 0;
    endtask

    task automatic write_inst(input logic [IW-1:0] v);
        @(posedge clk); #1;
        prog_v = 1'b1;
        prog_inst = v;
        @(posedge clk); #1;
        prog_v = 1'b0;
        if (model_plen < IN) begin
            exp_inst.push_back(v);
            model_plen++;
        end
    endtask

    task automatic start_job;
        obs_inst.delete(); obs_inst_cyc.delete();
        obs_din.delete(); obs_din_cyc.delete(); exp_din.delete(); exp_din_cyc.delete();
        obs_res.delete(); obs_res_cyc.delete(); exp_res.delete(); exp_res_cyc.delete();
        done_cnt = 0;
        load_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_feed(input bit gaps, input logic [2*DW-1:0] base);
        int n = 0;
        int b = 0;
        bit on = 1'b1;
        while (n < PE && b < 200) begin
            @(posedge clk); #1;
            src_v = on;
            src_data = base + 32'(n);
            @(negedge clk);
            if (src_v && src_rdy) begin
                exp_din.push_back(src_data);
                exp_din_cyc.push_back(cyc + 1);
                last_din_cyc = cyc + 1;
                n++;
            end
            if (gaps) on = !on;
            b++;
        end
        checks++;
        if (n != PE) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", n, PE);
        end
    endtask

    task automatic wait_load(output int lc);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!load && b < 200);
        lc = cyc;
        checks++;
        if (!load) begin
            errors++;
            $display("FAIL load_timeout: load=%0b after %0d cycles, required 1", load, b);
        end
    endtask

    task automatic do_drain(input bit gaps, input int start_at);
        for (int i = 0; i < PE; i++) begin
            if (gaps) begin
                int r;
                r = $urandom_range(0, 2);
                repeat (r) begin
                    @(posedge clk); #1;
                    dout_overlay_v = 1'b0;
                    start = 1'b0;
                end
            end
            @(posedge clk); #1;
            dout_overlay_v = 1'b1;
            dout_overlay = 32'h100 + 32'(i);
            start = (i == start_at);
            exp_res.push_back({1'(i == PE - 1), 32'h100 + 32'(i)});
            exp_res_cyc.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        dout_overlay_v = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done;
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!done && b < 100);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, b);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_job(input logic [2*DW-1:0] base, input int start_at);
        int lc;
        do_feed(1'b0, base);
        @(posedge clk); #1;
        src_v = 1'b0;
        wait_load(lc);
        do_drain(1'b1, start_at);
        wait_done();
    endtask

    task automatic test_reset;
        logic [8:0] outs;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {src_rdy, inst_in_v, din_overlay_v, load, res_v, res_last, busy, done, stray};
        checks++;
        if (outs !== 9'b0) begin
            errors++;
            $display("FAIL reset_held: outputs=%b, required %b", outs, 9'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        outs = {src_rdy, inst_in_v, din_overlay_v, load, res_v, res_last, busy, done, stray};
        checks++;
        if (outs !== 9'b0) begin
            errors++;
            $display("FAIL reset_release: outputs=%b, required %b", outs, 9'b0);
        end
    endtask

    task automatic test_no_prog;
        start_job();
        @(negedge clk);
        checks++;
        if (src_rdy !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL direct_feed: src_rdy=%b busy=%b, required 1 1", src_rdy, busy);
        end
    endtask

    task automatic test_feed_gaps;
        do_feed(1'b1, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            src_v = 1'b1;
            src_data = 32'hDEAD;
            @(negedge clk);
            checks++;
            if (src_rdy !== 1'b0) begin
                errors++;
                $display("FAIL rdy_after_feed: src_rdy=%b, required 0", src_rdy);
            end
        end
        @(posedge clk); #1;
        src_v = 1'b0;
        checks++;
        if (obs_din.size() != PE) begin
            errors++;
            $display("FAIL din_count: got %0d words, required %0d", obs_din.size(), PE);
        end
        while (exp_din.size() > 0 && obs_din.size() > 0) begin
            logic [2*DW-1:0] e, o;
            int ec, oc;
            e = exp_din.pop_front(); ec = exp_din_cyc.pop_front();
            o = obs_din.pop_front(); oc = obs_din_cyc.pop_front();
            checks++;
            if (o !== e || oc != ec) begin
                errors++;
                $display("FAIL din_word: got %0h at cycle %0d, required %0h at cycle %0d", o, oc, e, ec);
            end
        end
    endtask

    task automatic test_load_timing;
        int lc;
        wait_load(lc);
        checks++;
        if (lc != last_din_cyc + WC) begin
            errors++;
            $display("FAIL load_cycle: got cycle %0d, required %0d", lc, last_din_cyc + WC);
        end
        @(negedge clk);
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL load_width: load=%b one cycle later, required 0", load);
        end
    endtask

    task automatic test_drain;
        do_drain(1'b1, -1);
        wait_done();
        checks++;
        if (obs_res.size() != PE) begin
            errors++;
            $display("FAIL res_count: got %0d results, required %0d", obs_res.size(), PE);
        end
        while (exp_res.size() > 0 && obs_res.size() > 0) begin
            logic [2*DW:0] e, o;
            int ec, oc;
            e = exp_res.pop_front(); ec = exp_res_cyc.pop_front();
            o = obs_res.pop_front(); oc = obs_res_cyc.pop_front();
            checks++;
            if (o !== e || oc != ec) begin
                errors++;
                $display("FAIL res_word: got last/data %0h at cycle %0d, required %0h at cycle %0d", o, oc, e, ec);
            end
        end
        checks++;
        if (done_cnt != 1 || load_cnt != 1) begin
            errors++;
            $display("FAIL job_pulses: done=%0d load=%0d, required 1 1", done_cnt, load_cnt);
        end
        checks++;
        if (busy_fall_cyc != done_cyc + 1) begin
            errors++;
            $display("FAIL busy_fall: got cycle %0d, required %0d", busy_fall_cyc, done_cyc + 1);
        end
        checks++;
        if (obs_inst.size() != 0) begin
            errors++;
            $display("FAIL no_prog_inst: got %0d instructions, required 0", obs_inst.size());
        end
    endtask

    task automatic check_issue(input int n);
        checks++;
        if (obs_inst.size() != n) begin
            errors++;
            $display("FAIL inst_count: got %0d instructions, required %0d", obs_inst.size(), n);
        end
        for (int i = 0; i < n && i < obs_inst.size(); i++) begin
            checks++;
            if (obs_inst[i] !== exp_inst[i]) begin
                errors++;
                $display("FAIL inst_word %0d: got %0h, required %0h", i, obs_inst[i], exp_inst[i]);
            end
        end
        if (obs_inst.size() > 0) begin
            checks++;
            if (obs_inst_cyc[obs_inst.size()-1] - obs_inst_cyc[0] != obs_inst.size() - 1) begin
                errors++;
                $display("FAIL inst_contig: span %0d cycles, required %0d",
                         obs_inst_cyc[obs_inst.size()-1] - obs_inst_cyc[0], obs_inst.size() - 1);
            end
        end
    endtask

    task automatic test_program_issue;
        logic [IW-1:0] vals [3];
        vals = '{64'hA, 64'hB, 64'hC};
        @(posedge clk); #1;
        prog_clr = 1'b1;
        prog_v = 1'b1;
        prog_inst = 64'hBAD;
        @(posedge clk); #1;
        prog_clr = 1'b0;
        prog_v = 1'b0;
        exp_inst.delete();
        model_plen = 0;
        foreach (vals[i]) write_inst(vals[i]);
        start_job();
        repeat (6) @(negedge clk);
        check_issue(3);
        finish_job(32'h200, -1);
        checks++;
        if (done_cnt != 1 || obs_res.size() != PE) begin
            errors++;
            $display("FAIL prog_job_end: done=%0d results=%0d, required 1 %0d", done_cnt, obs_res.size(), PE);
        end
    endtask

    task automatic test_plen_overflow;
        prog_clear();
        for (int i = 0; i < IN + 1; i++) write_inst(64'h1000 + 64'(i));
        start_job();
        repeat (IN + 4) @(negedge clk);
        check_issue(IN);
        finish_job(32'h300, -1);
    endtask

    task automatic test_abuse;
        prog_clear();
        start_job();
        @(posedge clk); #1;
        dout_overlay_v = 1'b1;
        dout_overlay = 32'hBEEF;
        @(posedge clk); #1;
        dout_overlay_v = 1'b0;
        @(negedge clk);
        checks++;
        if (stray !== 1'b1) begin
            errors++;
            $display("FAIL stray_set: stray=%b, required 1", stray);
        end
        finish_job(32'h400, 3);
        checks++;
        if (stray !== 1'b1 || busy !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL drain_start_ignored: stray=%b busy=%b done=%0d, required 1 0 1", stray, busy, done_cnt);
        end
        checks++;
        if (obs_res.size() != PE) begin
            errors++;
            $display("FAIL stray_dropped: got %0d results, required %0d", obs_res.size(), PE);
        end
        start_job();
        @(negedge clk);
        checks++;
        if (stray !== 1'b0 || src_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stray_clear: stray=%b src_rdy=%b, required 0 1", stray, src_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            src_v = 1'b1;
            src_data = 32'h500 + 32'(k);
        end
        @(posedge clk); #1;
        src_v = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_inst.delete();
        model_plen = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || src_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b src_rdy=%b, required 0 0", busy, src_rdy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt != 0 || load_cnt != 0) begin
            errors++;
            $display("FAIL abort_no_done: done=%0d load=%0d, required 0 0", done_cnt, load_cnt);
        end
        start_job();
        finish_job(32'h600, -1);
        checks++;
        if (done_cnt != 1 || obs_res.size() != PE) begin
            errors++;
            $display("FAIL post_reset_job: done=%0d results=%0d, required 1 %0d", done_cnt, obs_res.size(), PE);
        end
        while (exp_res.size() > 0 && obs_res.size() > 0) begin
            logic [2*DW:0] e, o;
            e = exp_res.pop_front();
            o = obs_res.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset_res: got %0h, required %0h", o, e);
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_no_prog();
        test_feed_gaps();
        test_load_timing();
        test_drain();
        test_program_issue();
        test_plen_overflow();
        test_abuse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
